// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg : shared types and defaults for the SPI receive front end     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int SPI_DATA_W_DEFAULT      = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_rx_shifter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_rx_shifter_if : SPI pins plus received-word outputs               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface spi_rx_shifter_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
);
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              rx;
  logic              frame_err;

  modport master (
    output sclk, mosi, cs_n,
    input  data_out, data_valid, rx, frame_err
  );

  modport slave (
    input  sclk, mosi, cs_n,
    output data_out, data_valid, rx, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_edge : multi-stage synchroniser with rise/fall edge detection    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic d_async,
  output logic      q,
  output logic      rise,
  output logic      fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise = r_sync[STAGES-1] & ~r_prev;
  assign fall = ~r_sync[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_rx_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_rx_shifter : SPI mode-0 slave receiver, MSB-first word assembly   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module spi_rx_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input wire logic         clk,
  input wire logic         reset,
  spi_rx_shifter_if.slave  bus
);

  localparam int                 c_CNT_W = $clog2(DATA_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_cs_q,   w_cs_rise,   w_cs_fall;
  logic [3:0] w_unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_async(bus.sclk),
    .q(w_sclk_q), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_async(bus.mosi),
    .q(w_mosi_q), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  // cs_n resets to its idle-high level so leaving reset never looks like a frame start
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d_async(bus.cs_n),
    .q(w_cs_q), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  assign w_unused_edges = {w_sclk_q, w_sclk_fall, w_mosi_rise ^ w_mosi_fall, w_cs_fall};

  rx_state_t           r_state, w_next_state;
  logic [DATA_W-1:0]   r_shift, w_shift;
  logic [c_CNT_W-1:0]  r_cnt,   w_cnt;
  logic [DATA_W-1:0]   r_data,  w_data;
  logic                r_valid, w_valid;
  logic                r_err,   w_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_shift <= w_shift;
      r_cnt   <= w_cnt;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_shift      = r_shift;
    w_cnt        = r_cnt;
    w_data       = r_data;
    w_valid      = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs_q) begin
          w_next_state = SHIFT;
          w_shift      = '0;
          w_cnt        = '0;
        end
      end
      SHIFT: begin
        if (w_sclk_rise) begin
          w_shift = {r_shift[DATA_W-2:0], w_mosi_q};
          if (r_cnt == c_LAST) begin
            w_cnt   = '0;
            w_data  = w_shift;
            w_valid = 1'b1;
          end else begin
            w_cnt = r_cnt + c_ONE;
          end
        end
        // Frame close sees the post-shift count, so a last bit landing with cs_rise completes cleanly
        if (w_cs_rise) begin
          w_next_state = FLUSH;
          w_err        = (w_cnt != '0);
        end
      end
      FLUSH: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.rx         = (r_state == SHIFT);
  assign bus.frame_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_rx_shifter : directed self-checking bench for spi_rx_shifter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_spi_rx_shifter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  spi_rx_shifter_if #(.DATA_W(8)) bus ();

  spi_rx_shifter #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Passive monitor of output pulses, sampled on the falling edge
  logic [7:0] words[$];
  int   err_seen = 0;
  int   rx_rises = 0;
  logic rx_q     = 1'b0;

  always @(negedge clk) begin
    if (bus.data_valid) words.push_back(bus.data_out);
    if (bus.frame_err) err_seen++;
    if (bus.rx && !rx_q) rx_rises++;
    rx_q = bus.rx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.mosi = b;
    wait_n(4);
    bus.sclk = 1'b1;
    wait_n(4);
    bus.sclk = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic cs_start();
    bus.cs_n = 1'b0;
    wait_n(4);
  endtask

  task automatic cs_end();
    wait_n(4);
    bus.cs_n = 1'b1;
    wait_n(10);
  endtask

  initial begin
    int w0, e0, r0;

    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.cs_n = 1'b1;
    reset    = 1'b1;
    wait_n(3);
    check("rst_data_out",   32'(bus.data_out),   32'h0);
    check("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check("rst_rx",         32'(bus.rx),         32'h0);
    check("rst_frame_err",  32'(bus.frame_err),  32'h0);
    reset = 1'b0;
    wait_n(4);

    // Single word 0xA5, with rx rise latency of three clocks
    w0 = words.size(); e0 = err_seen; r0 = rx_rises;
    bus.cs_n = 1'b0;
    wait_n(2);
    check("rx_lat_before", 32'(bus.rx), 32'h0);
    wait_n(1);
    check("rx_lat_at",     32'(bus.rx), 32'h1);
    wait_n(1);
    send_word(8'hA5);
    cs_end();
    check("a5_count",    32'(words.size() - w0), 32'd1);
    check("a5_word",     32'(words[w0]),         32'hA5);
    check("a5_data_out", 32'(bus.data_out),      32'hA5);
    check("a5_err",      32'(err_seen - e0),     32'd0);
    check("a5_rx_low",   32'(bus.rx),            32'h0);
    check("a5_rx_rises", 32'(rx_rises - r0),     32'd1);

    // Two words in one frame
    w0 = words.size(); e0 = err_seen; r0 = rx_rises;
    cs_start();
    send_word(8'h3C);
    send_word(8'hC3);
    cs_end();
    check("two_count",    32'(words.size() - w0), 32'd2);
    check("two_first",    32'(words[w0]),         32'h3C);
    check("two_second",   32'(words[w0 + 1]),     32'hC3);
    check("two_data_out", 32'(bus.data_out),      32'hC3);
    check("two_rx_rises", 32'(rx_rises - r0),     32'd1);
    check("two_err",      32'(err_seen - e0),     32'd0);

    // Full word then five stray bits: partial word is dropped
    w0 = words.size(); e0 = err_seen; r0 = rx_rises;
    cs_start();
    send_word(8'h5A);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    cs_end();
    check("part_count",    32'(words.size() - w0), 32'd1);
    check("part_err",      32'(err_seen - e0),     32'd1);
    check("part_data_out", 32'(bus.data_out),      32'h5A);
    check("part_rx_low",   32'(bus.rx),            32'h0);

    // CS_N rises together with the 8th SCLK edge
    w0 = words.size(); e0 = err_seen;
    cs_start();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    bus.mosi = 1'b1;
    wait_n(4);
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    wait_n(4);
    bus.sclk = 1'b0;
    wait_n(10);
    check("coinc_count",    32'(words.size() - w0), 32'd1);
    check("coinc_data_out", 32'(bus.data_out),      32'hFF);
    check("coinc_err",      32'(err_seen - e0),     32'd0);

    // Reset in the middle of a frame
    w0 = words.size(); e0 = err_seen;
    cs_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    reset    = 1'b1;
    bus.cs_n = 1'b1;
    wait_n(1);
    check("mid_rst_data_out", 32'(bus.data_out),   32'h0);
    check("mid_rst_valid",    32'(bus.data_valid), 32'h0);
    check("mid_rst_rx",       32'(bus.rx),         32'h0);
    check("mid_rst_err",      32'(bus.frame_err),  32'h0);
    wait_n(1);
    reset = 1'b0;
    wait_n(4);
    check("mid_rst_no_word", 32'(words.size() - w0), 32'd0);
    w0 = words.size();
    cs_start();
    send_word(8'h81);
    cs_end();
    check("post_rst_count",    32'(words.size() - w0), 32'd1);
    check("post_rst_data_out", 32'(bus.data_out),      32'h81);
    check("post_rst_err",      32'(err_seen - e0),     32'd0);

    // SCLK activity with CS_N high, then an empty frame
    w0 = words.size(); e0 = err_seen; r0 = rx_rises;
    for (int i = 0; i < 8; i++) begin
      bus.mosi = i[0];
      bus.sclk = 1'b1;
      wait_n(4);
      bus.sclk = 1'b0;
      wait_n(4);
    end
    check("idle_sclk_rx_rises", 32'(rx_rises - r0), 32'd0);
    cs_start();
    wait_n(4);
    cs_end();
    check("empty_count",    32'(words.size() - w0), 32'd0);
    check("empty_err",      32'(err_seen - e0),     32'd0);
    check("empty_data_out", 32'(bus.data_out),      32'h81);
    check("empty_rx_rises", 32'(rx_rises - r0),     32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_rx_shifter.md
Name: spi_rx_shifter

Overview:
- SPI mode-0 slave receive front end in the FPGA clock domain.
- Synchronises SCLK, MOSI and CS_N, then shifts MOSI in MSB-first on each SCLK rising edge.
- Presents each completed word on data_out.
- Drives rx high for the duration of a frame, so the downstream LED register controller's high-then-low detection loads the last completed word.

Parameters:
DATA_W, 8, bits per SPI word.
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).

Ports:
clk  in  1  system clock; must be at least 4x SCLK frequency.
reset  in  1  synchronous, active-high reset.
sclk  in  1  SPI clock from master, asynchronous to clk, idle low.
mosi  in  1  SPI data from master, asynchronous to clk.
cs_n  in  1  SPI chip select, active low, asynchronous to clk.
data_out  out  DATA_W  last completed word; held until the next word completes.
data_valid  out  1  one-clk pulse on the cycle data_out updates.
rx  out  1  frame-active flag; feeds the LED register controller.
frame_err  out  1  one-clk pulse when CS_N deasserts with a partial word.

Behaviour:
- Reset (reset=1 at posedge clk): all outputs are 0, FSM goes to IDLE, bit counter is 0, shift register is 0. Reset wins over every other event, including reset mid-frame.
- Synchronisation:
  - sclk, mosi and cs_n each pass through SYNC_STAGES flip-flops.
  - sclk_rise = synced sclk is 1 and its previous value was 0.
  - cs_fall and cs_rise are derived the same way from synced cs_n.
  - mosi is sampled from its synced copy, so it is aligned with the sclk edge.
- FSM states: IDLE, SHIFT, FLUSH.
  - IDLE: rx=0, shift activity ignored. On synced cs_n=0, go to SHIFT; clear the bit counter and shift register.
  - SHIFT: rx=1. On sclk_rise, shift_reg <= {shift_reg[DATA_W-2:0], mosi_s} and bit_cnt++.
  - Word completion: when an sclk_rise brings bit_cnt to DATA_W, on that same cycle data_out <= the new shifted value, data_valid=1 and bit_cnt <= 0. Stay in SHIFT, because multiple words per frame are allowed.
  - SHIFT exit: on cs_rise go to FLUSH. If bit_cnt != 0, pulse frame_err, discard the partial word and leave data_out unchanged.
  - FLUSH: rx=0 for one cycle, then IDLE. FLUSH guarantees rx has a falling edge after data_out is stable.
- Latency:
  - data_out and data_valid update SYNC_STAGES+1 clk cycles after the physical SCLK edge carrying the last bit.
  - rx rises SYNC_STAGES+1 cycles after CS_N falls and falls SYNC_STAGES+1 cycles after CS_N rises.
- Simultaneous events:
  - sclk_rise and cs_rise on the same cycle: the shift happens first (and may complete a word), then the frame closes. frame_err uses the post-shift bit_cnt.
  - sclk_rise while in IDLE or FLUSH is ignored.
- A frame with zero SCLK edges: rx pulses high and no data_valid. A downstream register reload of the unchanged data_out is acceptable.
- bit_cnt width is clog2(DATA_W+1) and never exceeds DATA_W.

Decomposition:
- Shared package spi_pkg holds:
  - the rx_state_t enum typedef (IDLE, SHIFT, FLUSH);
  - the localparam SPI_DATA_W_DEFAULT=8;
  - the localparam SPI_SYNC_STAGES_DEFAULT=2.
- Sub-module sync_edge (parameter STAGES; ports clk, reset, d_async, q, rise, fall), instantiated once each for sclk, mosi and cs_n. Only q is used for mosi.

Test Plan:
- Reset, then a frame sending 0xA5 at SCLK=clk/8 -> one data_valid, data_out=0xA5, rx rises after CS_N falls and drops after CS_N rises, frame_err=0.
- One frame containing 0x3C then 0xC3 -> two data_valid pulses in order, final data_out=0xC3, a single rx high period.
- Frame with 0x5A followed by 5 bits, then CS_N rises -> frame_err pulses once, data_out remains 0x5A, rx falls normally.
- CS_N rises on the same clk as the 8th SCLK edge of 0xFF (after sync) -> data_out=0xFF, data_valid=1, frame_err=0.
- reset asserted after 4 bits of a frame -> all outputs 0 on the next cycle; a following complete frame of 0x81 is received correctly.
- SCLK toggling with CS_N high, then a frame with no SCLK edges -> no data_valid, no frame_err, data_out unchanged, rx pulses only for the CS_N-low frame.
